// File: rtl/ccu_issue_ctrl.sv
// Issue controller for the CalculateUnit: round-robin arbitration between the
// integer pipeline (port 0) and the debug/aux requester (port 1), registered
// operand/mode drive, fast/slow result wait, and a held response with a
// saturating error counter. One operation is outstanding at a time.
module ccu_issue_ctrl #(
  parameter int unsigned SLOW_LAT = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_num1,
  input  logic [31:0]      req0_num2,
  input  logic [7:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_num1,
  input  logic [31:0]      req1_num2,
  input  logic [7:0]       req1_mode,
  output logic [31:0]      ccu_num1,
  output logic [31:0]      ccu_num2,
  output logic [7:0]       ccu_mode,
  input  logic [31:0]      ccu_fast_ans,
  input  logic [31:0]      ccu_slow_ans,
  input  logic [3:0]       ccu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic [3:0]       rsp_error,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0]       SLOW_LAT_C   = 4'(SLOW_LAT);
  localparam logic [3:0]       MODE_GRP_MD  = 4'h4;
  localparam logic [3:0]       ERR_NONE     = 4'd0;
  localparam logic [3:0]       ERR_NO_INSTR = 4'd1;
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       ccu_num1_q, ccu_num1_d;
  logic [31:0]       ccu_num2_q, ccu_num2_d;
  logic [7:0]        ccu_mode_q, ccu_mode_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [3:0]        rsp_error_q, rsp_error_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              grant0_s, grant1_s;

  // An unknown instruction must never leak a stale answer to the requester.
  function automatic logic [31:0] gate_data(input logic [31:0] ans, input logic [3:0] err);
    if (err == ERR_NO_INSTR) begin
      return 32'd0;
    end else begin
      return ans;
    end
  endfunction

  // Grant only in IDLE; on contention the port that did not win last time goes.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0_s = last_grant_q;
        grant1_s = ~last_grant_q;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Next-state and next-output computation for the issue FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ccu_num1_d   = ccu_num1_q;
    ccu_num2_d   = ccu_num2_q;
    ccu_mode_d   = ccu_mode_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant0_s) begin
          ccu_num1_d   = req0_num1;
          ccu_num2_d   = req0_num2;
          ccu_mode_d   = req0_mode;
          rsp_id_d     = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (grant1_s) begin
          ccu_num1_d   = req1_num1;
          ccu_num2_d   = req1_num2;
          ccu_mode_d   = req1_mode;
          rsp_id_d     = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (ccu_mode_q[7:4] == MODE_GRP_MD) begin
          cnt_d   = SLOW_LAT_C;
          state_d = WAIT;
        end else begin
          rsp_data_d  = gate_data(ccu_fast_ans, ccu_error);
          rsp_error_d = ccu_error;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          rsp_data_d  = gate_data(ccu_slow_ans, ccu_error);
          rsp_error_d = ccu_error;
          rsp_valid_d = 1'b1;
          cnt_d       = 4'd0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if ((rsp_error_q != ERR_NONE) && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      ccu_num1_q   <= 32'd0;
      ccu_num2_q   <= 32'd0;
      ccu_mode_q   <= 8'h01;
      cnt_q        <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_error_q  <= 4'd0;
      busy_q       <= 1'b0;
      err_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ccu_num1_q   <= ccu_num1_d;
      ccu_num2_q   <= ccu_num2_d;
      ccu_mode_q   <= ccu_mode_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
      busy_q       <= busy_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign ccu_num1   = ccu_num1_q;
  assign ccu_num2   = ccu_num2_q;
  assign ccu_mode   = ccu_mode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_error  = rsp_error_q;
  assign busy       = busy_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/ccu_issue_ctrl.md
Name: ccu_issue_ctrl

Overview:
Issue controller and two-port arbiter in front of the CalculateUnit. It accepts operation requests from two requesters (port 0 = integer pipeline, port 1 = debug/auxiliary), arbitrates round-robin, and drives the operands and mode registered and held stable. It waits the correct number of cycles for the fast path (ALU/BALU) or the slow path (MulDiv, mode[7:4]==4'h4), then returns one tagged response with data and error code.

Parameters:
SLOW_LAT, 1, cycles from the first operand-present cycle until slow_answer is valid (legal 1..15).
CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 accepted (combinational grant)
req0_num1  in  32  port 0 operand 1
req0_num2  in  32  port 0 operand 2
req0_mode  in  8  port 0 CCU mode code
req1_valid  in  1  port 1 request valid
req1_ready  out  1  port 1 accepted
req1_num1  in  32  port 1 operand 1
req1_num2  in  32  port 1 operand 2
req1_mode  in  8  port 1 CCU mode code
ccu_num1  out  32  registered operand 1 to CalculateUnit
ccu_num2  out  32  registered operand 2 to CalculateUnit
ccu_mode  out  8  registered mode to CalculateUnit
ccu_fast_ans  in  32  CalculateUnit fast_answer
ccu_slow_ans  in  32  CalculateUnit slow_answer
ccu_error  in  4  CalculateUnit error (0 none, 1 NO_INSTRUCTION, 2 DIV_BY_ZERO)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that owns the response
rsp_data  out  32  result
rsp_error  out  4  latched error code
busy  out  1  high in any state except IDLE
err_cnt  out  CNT_W  saturating count of responses with rsp_error!=0

Behaviour:
- Reset (async, rstn=0): state=IDLE; ccu_num1/num2=0; ccu_mode=8'h01 (ADD); rsp_valid=0; rsp_id=0; rsp_data=0; rsp_error=0; err_cnt=0; last_grant=1, so port 0 wins first. An in-flight op is discarded and produces no response.
- States: IDLE, EXEC, WAIT, RESP.
- IDLE: req*_ready is combinational and is high only in IDLE.
  - Only one valid: grant it.
  - Both valid: grant the port != last_grant.
  - On handshake (cycle T): latch that port's num1/num2/mode into ccu_*, set the owner id, update last_grant, go to EXEC.
  - No valid: stay in IDLE; ccu_* hold their values.
- EXEC (T+1): the CCU sees the operands.
  - Fast op (mode[7:4]!=4'h4): capture rsp_data=ccu_fast_ans and rsp_error=ccu_error at the end of the cycle, go to RESP. rsp_valid is high at T+2.
  - Slow op: load cnt=SLOW_LAT, go to WAIT.
- WAIT: decrement cnt each cycle. In the cycle where cnt==1, capture ccu_slow_ans and ccu_error and go to RESP. rsp_valid is high at T+2+SLOW_LAT (T+3 by default). ccu_* stay stable throughout.
- ccu_error==1 (NO_INSTRUCTION): force rsp_data=0 and return error 1. The unit does not hang.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_error are held stable until rsp_ready.
  - On rsp_valid&rsp_ready: drop rsp_valid, go to IDLE. The next grant is possible in the following cycle, so minimum issue spacing is 3 cycles (fast ops).
  - Backpressure of any length is legal; no new grant happens while in RESP.
- err_cnt increments by 1 on each accepted response with rsp_error!=0 and saturates at all-ones.
- Requesters must hold num/mode stable while valid and not ready. A valid that drops before ready is simply not granted.
- Only one operation is outstanding at a time; there is no pipelining across requests.

Test Plan:
1. Port 0: ADD (8'h01), 5, 7; rsp_ready=1 -> rsp_valid at T+2, rsp_data=12, rsp_id=0, rsp_error=0.
2. Port 1: MUL (8'h40), 6, 7; SLOW_LAT=1 -> rsp_valid at T+3, rsp_data=42, rsp_id=1; ccu_mode==8'h40 held through WAIT.
3. Both ports valid continuously with SUB 10-3 (port 0) and XOR 0xF0^0x0F (port 1) -> grants alternate 0,1,0,1; responses 7, 0xFF, 7, 0xFF with matching rsp_id.
4. DIV (8'h44), 9, 0 -> rsp_error=2 and err_cnt=1. Mode 8'hEE -> rsp_error=1, rsp_data=0, err_cnt=2. At saturation (CNT_W=2) err_cnt stays at 3.
5. rsp_ready held low for 5 cycles after rsp_valid -> data, id and error stable; both req*_ready stay 0; on release, return to IDLE and the next grant follows one cycle later.
6. rstn pulsed low during WAIT of a MUL -> all outputs take reset values immediately, no response is ever produced, and the first grant after reset goes to port 0.
